// File: rtl/uart_rx_echo.sv
// 8N1 UART receiver (LSB first) that re-transmits every correctly framed byte on DI.
// Receiver and transmitter are independent FSMs; a byte completing while an echo is busy is dropped.
module uart_rx_echo #(
    parameter int BIT_CLKS  = 5200,
    parameter int HALF_CLKS = BIT_CLKS / 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic Rx,
    output logic DI,
    output logic enviando
);

    localparam int CW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE, T_START, T_DATA, T_STOP
    } tx_state_t;

    // Synchroniser flops reset to the idle line level so reset release never looks like a start bit.
    logic rx_meta, rx_s;

    rx_state_t      rx_state, rx_state_n;
    logic [CW-1:0]  rx_cnt, rx_cnt_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [7:0]     rx_shreg, rx_shreg_n;
    logic           byte_ok;

    tx_state_t      tx_state, tx_state_n;
    logic [CW-1:0]  tx_cnt, tx_cnt_n;
    logic [2:0]     tx_bit, tx_bit_n;
    logic [7:0]     tx_data, tx_data_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
        end else begin
            rx_meta  <= Rx;
            rx_s     <= rx_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_data  <= tx_data_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        byte_ok    = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s) rx_state_n = R_START;
            end
            R_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shreg_n = {rx_s, rx_shreg[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_s) begin
                        byte_ok    = 1'b1;
                        rx_state_n = R_IDLE;
                    end else begin
                        rx_state_n = R_WAIT_HIGH;
                    end
                end
            end
            R_WAIT_HIGH: begin
                rx_cnt_n = '0;
                if (rx_s) rx_state_n = R_IDLE;
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_data_n  = tx_data;
        unique case (tx_state)
            T_IDLE: begin
                tx_cnt_n = '0;
                if (byte_ok) begin
                    tx_data_n  = rx_shreg;
                    tx_state_n = T_START;
                end
            end
            T_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = T_DATA;
                end
            end
            T_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_n = T_STOP;
                end
            end
            T_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = T_IDLE;
                end
            end
            default: tx_state_n = T_IDLE;
        endcase
    end

    // Line level is a pure decode of the transmitter state, so reset forces it high at once.
    always_comb begin
        DI       = 1'b1;
        enviando = (tx_state != T_IDLE);
        if (tx_state == T_START)     DI = 1'b0;
        else if (tx_state == T_DATA) DI = tx_data[tx_bit];
    end

endmodule

// File: tb/tb_uart_rx_echo.sv
// Bench for uart_rx_echo at a short bit time: frames are driven on Rx, expected echoes
// (byte plus exact start cycle) are queued and checked bit-by-bit on DI/enviando.
module tb_uart_rx_echo;

    localparam int BIT  = 16;
    localparam int HALF = 8;
    // Rx start driven before posedge P1; 2 sync edges, half bit, 9 bits, then DI falls.
    localparam int LAT  = 3 + HALF + 9 * BIT;

    logic CLK, RST_N, Rx;
    logic DI, enviando;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic mon_en = 1'b1;

    logic [39:0] exp_q[$];

    uart_rx_echo #(.BIT_CLKS(BIT), .HALF_CLKS(HALF)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .Rx(Rx),
        .DI(DI),
        .enviando(enviando)
    );

    // clock/reset block
    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_len, input logic expect_echo);
        @(negedge CLK);
        Rx = 1'b0;
        if (expect_echo) exp_q.push_back({32'(cyc + LAT), d});
        repeat (BIT - 1) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            Rx = d[i];
            repeat (BIT - 1) @(negedge CLK);
        end
        @(negedge CLK);
        Rx = stop_val;
        repeat (stop_len - 1) @(negedge CLK);
    endtask

    task automatic hold_rx(input logic level, input int n);
        @(negedge CLK);
        Rx = level;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !enviando) break;
            @(negedge CLK);
        end
        check(tag, 40'(exp_q.size() == 0 && !enviando), 40'd1);
    endtask

    // scoreboard: pops an expectation whenever an echo frame starts on DI
    initial begin
        logic [39:0] e;
        logic        eb;
        forever begin
            @(negedge CLK);
            if (mon_en && RST_N && DI === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_echo", 40'd1, 40'd0);
                    while (DI === 1'b0 || enviando === 1'b1) @(negedge CLK);
                end else begin
                    e = exp_q.pop_front();
                    check("echo_start_cycle", 40'(cyc), 40'(e[39:8]));
                    for (int k = 0; k < 10; k++) begin
                        eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e[k - 1];
                        for (int j = 0; j < BIT; j++) begin
                            if (k != 0 || j != 0) @(negedge CLK);
                            check($sformatf("echo_%02h_bit%0d_di", e[7:0], k), 40'(DI), 40'(eb));
                            check("echo_enviando_high", 40'(enviando), 40'd1);
                        end
                    end
                    @(negedge CLK);
                    check("echo_end_enviando", 40'(enviando), 40'd0);
                    check("echo_end_di", 40'(DI), 40'd1);
                end
            end
        end
    end

    initial begin
        int tmo;
        Rx    = 1'b1;
        RST_N = 1'b0;
        repeat (4) @(negedge CLK);
        check("reset_di", 40'(DI), 40'd1);
        check("reset_enviando", 40'(enviando), 40'd0);
        RST_N = 1'b1;
        hold_rx(1'b1, BIT);
        check("idle_di", 40'(DI), 40'd1);

        // 0x55, then 0x9A starting during the first echo
        send_frame(8'h55, 1'b1, BIT, 1'b1);
        hold_rx(1'b1, 2 * BIT);
        send_frame(8'h9A, 1'b1, BIT, 1'b1);
        wait_drain("drain_55_9a", 40 * BIT);

        // glitch shorter than the start-bit centring delay
        hold_rx(1'b0, HALF - 2);
        for (int i = 0; i < 12 * BIT; i++) begin
            @(negedge CLK);
            Rx = 1'b1;
            if (enviando !== 1'b0) begin
                check("false_start_no_echo", 40'(enviando), 40'd0);
                break;
            end
        end
        check("false_start_quiet", 40'(enviando), 40'd0);
        send_frame(8'h3C, 1'b1, BIT, 1'b1);
        wait_drain("drain_after_glitch", 30 * BIT);

        // framing error followed by a break, then a good frame
        send_frame(8'h0F, 1'b0, BIT, 1'b0);
        hold_rx(1'b0, 12 * BIT);
        check("framing_no_echo", 40'(enviando), 40'd0);
        hold_rx(1'b1, 2 * BIT);
        send_frame(8'hA5, 1'b1, BIT, 1'b1);
        wait_drain("drain_a5", 30 * BIT);

        // overrun: second byte completes while the first is still echoing
        send_frame(8'hC6, 1'b1, HALF + 4, 1'b1);
        send_frame(8'h39, 1'b1, BIT, 1'b0);
        wait_drain("drain_overrun", 30 * BIT);
        hold_rx(1'b1, 15 * BIT);
        check("overrun_quiet", 40'(enviando), 40'd0);

        // random bytes with random idle gaps
        for (int n = 0; n < 3; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, BIT, 1'b1);
            hold_rx(1'b1, $urandom_range(11 * BIT, 14 * BIT));
        end
        wait_drain("drain_random", 40 * BIT);

        // asynchronous reset in the middle of an echo
        mon_en = 1'b0;
        send_frame(8'h00, 1'b1, BIT, 1'b0);
        tmo = 0;
        while (enviando !== 1'b1 && tmo < 4 * BIT) begin
            @(negedge CLK);
            tmo++;
        end
        check("midecho_started", 40'(enviando), 40'd1);
        repeat (3 * BIT) @(negedge CLK);
        check("midecho_di_low", 40'(DI), 40'd0);
        #3 RST_N = 1'b0;
        #1;
        check("async_reset_di", 40'(DI), 40'd1);
        check("async_reset_enviando", 40'(enviando), 40'd0);
        repeat (3) @(negedge CLK);
        check("held_reset_di", 40'(DI), 40'd1);
        RST_N = 1'b1;
        hold_rx(1'b1, 2 * BIT);
        check("post_reset_idle", 40'(enviando), 40'd0);
        mon_en = 1'b1;
        send_frame(8'h81, 1'b1, BIT, 1'b1);
        wait_drain("drain_post_reset", 30 * BIT);

        check("queue_empty", 40'(exp_q.size()), 40'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
